// File: rtl/framebuffer_writer_pkg.sv
// Types and constants shared by the framebuffer writer and its FIFO.
package framebuffer_writer_pkg;
  `include "raster_defines.svh"

  localparam int COLOR_W       = `COLOR_BITS;
  localparam int FX_FRAC       = `FX_FRAC_BITS;
  localparam int FX_TOTAL_W    = `FX_TOTAL_BITS;
  localparam int FB_WIDTH_DEF  = `FB_WIDTH_DEFAULT;
  localparam int FB_HEIGHT_DEF = `FB_HEIGHT_DEFAULT;
  localparam int FB_ADDR_W     = `FB_ADDR_BITS;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_CLEAR  = 2'd2
  } fbw_state_e;
endpackage

// File: rtl/raster_defines.svh
// Raster pipeline shared definitions: color/fixed-point widths, default screen size
// and the coordinate / framebuffer-write record types.
`ifndef RASTER_DEFINES_SVH
`define RASTER_DEFINES_SVH

`define COLOR_BITS        24
`define FX_FRAC_BITS      4
`define FX_TOTAL_BITS     16
`define FB_WIDTH_DEFAULT  320
`define FB_HEIGHT_DEFAULT 240
`define FB_ADDR_BITS      17

typedef struct packed {
  logic signed [`FX_TOTAL_BITS-1:0] x;
  logic signed [`FX_TOTAL_BITS-1:0] y;
} coord_2d_t;

typedef struct packed {
  logic [`FB_ADDR_BITS-1:0] addr;
  logic [`COLOR_BITS-1:0]   color;
} fb_write_t;

`endif

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/framebuffer_writer.sv
// Turns shaded fragments into framebuffer writes (bounds check, linear address,
// FIFO buffering) and performs full-screen clears on request.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int FB_WIDTH   = FB_WIDTH_DEF,
  parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = FB_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [COLOR_W-1:0] in_color,
  input  coord_2d_t          in_pixel,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               fb_we,
  input  logic               fb_rdy,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic [15:0]        drop_count
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [FX_TOTAL_W-1:0] W_S = FX_TOTAL_W'(FB_WIDTH);
  localparam logic signed [FX_TOTAL_W-1:0] H_S = FX_TOTAL_W'(FB_HEIGHT);
  localparam logic [ADDR_W:0] CLEAR_END = (ADDR_W+1)'(FB_WIDTH * FB_HEIGHT);

  fbw_state_e state, state_nxt;
  logic                         active;
  logic signed [FX_TOTAL_W-1:0] xi, yi;
  logic                         in_bounds;
  logic [ADDR_W-1:0]            lin_addr;
  fb_write_t                    push_entry, head_entry;
  logic [$bits(fb_write_t)-1:0] head_raw;
  logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]             fifo_count;
  logic [CNT_W:0]               pending;
  logic                         xfer, slot_free, do_bypass, do_clear_wr;
  logic                         clear_issued, last_done;
  logic [ADDR_W:0]              clear_addr;
  logic [COLOR_W-1:0]           clear_color_q;

  always_comb begin
    xi         = in_pixel.x >>> FX_FRAC;
    yi         = in_pixel.y >>> FX_FRAC;
    in_bounds  = !xi[FX_TOTAL_W-1] && (xi < W_S) && !yi[FX_TOTAL_W-1] && (yi < H_S);
    lin_addr   = ADDR_W'(yi) * ADDR_W'(FB_WIDTH) + ADDR_W'(xi);
    push_entry.addr  = FB_ADDR_W'(lin_addr);
    push_entry.color = in_color;
    head_entry = fb_write_t'(head_raw);
  end

  sync_fifo #(.WIDTH($bits(fb_write_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_NORMAL: if (clear_req) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty && slot_free) state_nxt = ST_CLEAR;
      ST_CLEAR:  if (last_done) state_nxt = ST_NORMAL;
      default:   state_nxt = ST_NORMAL;
    endcase
  end

  // Handshakes: a beat moves on in_vld && in_rdy and on fb_we && fb_rdy; a presented
  // write holds addr/data until taken. in_rdy depends only on registered state, and
  // the output register counts toward occupancy so at most FIFO_DEPTH are in flight.
  always_comb begin
    pending      = {1'b0, fifo_count} + (CNT_W+1)'(fb_we);
    in_rdy       = active && (state == ST_NORMAL) && !fifo_full
                   && (pending < (CNT_W+1)'(FIFO_DEPTH));
    xfer         = in_vld && in_rdy;
    slot_free    = !fb_we || fb_rdy;
    clear_issued = (clear_addr == CLEAR_END);
    fifo_pop     = slot_free && !fifo_empty && (state != ST_CLEAR);
    do_bypass    = xfer && in_bounds && slot_free && fifo_empty;
    fifo_push    = xfer && in_bounds && !do_bypass;
    do_clear_wr  = (state == ST_CLEAR) && slot_free && !clear_issued;
    last_done    = (state == ST_CLEAR) && fb_we && fb_rdy && clear_issued;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active        <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_wdata      <= '0;
      clear_busy    <= 1'b0;
      clear_addr    <= '0;
      clear_color_q <= '0;
      drop_count    <= '0;
    end else begin
      active <= 1'b1;
      if (slot_free) begin
        if (fifo_pop) begin
          fb_we    <= 1'b1;
          fb_addr  <= ADDR_W'(head_entry.addr);
          fb_wdata <= head_entry.color;
        end else if (do_bypass) begin
          fb_we    <= 1'b1;
          fb_addr  <= lin_addr;
          fb_wdata <= in_color;
        end else if (do_clear_wr) begin
          fb_we      <= 1'b1;
          fb_addr    <= clear_addr[ADDR_W-1:0];
          fb_wdata   <= clear_color_q;
          clear_addr <= clear_addr + 1'b1;
        end else begin
          fb_we <= 1'b0;
        end
      end
      if ((state == ST_NORMAL) && clear_req) begin
        clear_busy    <= 1'b1;
        clear_color_q <= clear_color;
        clear_addr    <= '0;
      end else if (last_done) begin
        clear_busy <= 1'b0;
      end
      if (xfer && !in_bounds && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomized bench for framebuffer_writer against a queue-based model of the write stream.
module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

  localparam int FBW    = 320;
  localparam int FBH    = 240;
  localparam int PIX    = FBW * FBH;
  localparam int SW     = $bits(coord_2d_t) + COLOR_W;
  localparam int EXP_W  = 2 + 17 + COLOR_W;

  logic               clk;
  logic               rst;
  logic               in_vld;
  logic               in_rdy;
  logic [COLOR_W-1:0] in_color;
  coord_2d_t          in_pixel;
  logic               clear_req;
  logic [COLOR_W-1:0] clear_color;
  logic               clear_busy;
  logic               fb_we;
  logic               fb_rdy;
  logic [16:0]        fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic [15:0]        drop_count;

  framebuffer_writer dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_color(in_color),
    .in_pixel(in_pixel), .clear_req(clear_req), .clear_color(clear_color),
    .clear_busy(clear_busy), .fb_we(fb_we), .fb_rdy(fb_rdy), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [SW-1:0]    stim_q[$];
  int   m_drop = 0;
  bit   m_busy = 0;
  int   m_inb = 0;
  int   n_clear_wr = 0;
  int   n_frag_wr = 0;
  int   n_acc = 0;
  int   rdy_mode = 0;
  bit   clear_pulse = 0;
  logic [COLOR_W-1:0] clear_col_next = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int v);
    int d;
    d = 1 << FX_FRAC;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic logic [SW-1:0] make_frag(input int xq, input int yq,
                                               input logic [COLOR_W-1:0] c);
    coord_2d_t p;
    p.x = FX_TOTAL_W'(xq);
    p.y = FX_TOTAL_W'(yq);
    return {p, c};
  endfunction

  // Reference model: every accepted fragment / clear becomes expected writes, in order.
  always @(negedge clk) begin
    bit busy_now;
    logic [EXP_W-1:0] e;
    int xs, ys, xi, yi;
    if (rst) begin
      exp_q.delete();
      m_busy = 0;
      m_drop = 0;
    end else begin
      busy_now = m_busy;
      check("clear_busy", clear_busy, m_busy);
      if (fb_we && fb_rdy) begin
        if (exp_q.size() == 0) check("unexpected_write", {fb_addr, fb_wdata}, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", fb_addr, e[COLOR_W +: 17]);
          check("wr_data", fb_wdata, e[COLOR_W-1:0]);
          if (e[EXP_W-1]) n_clear_wr++;
          else n_frag_wr++;
          if (e[EXP_W-2]) m_busy = 0;
        end
      end
      if (in_vld && in_rdy) begin
        xs = $signed(in_pixel.x);
        ys = $signed(in_pixel.y);
        xi = floor_div(xs);
        yi = floor_div(ys);
        if (xi >= 0 && xi < FBW && yi >= 0 && yi < FBH) begin
          exp_q.push_back({2'b00, 17'(yi * FBW + xi), in_color});
          m_inb++;
        end else if (m_drop < 65535) m_drop++;
      end
      if (clear_req && !busy_now) begin
        m_busy = 1;
        for (int a = 0; a < PIX; a++)
          exp_q.push_back({1'b1, (a == PIX - 1), 17'(a), clear_color});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (in_vld && in_rdy) begin
      void'(stim_q.pop_front());
      n_acc++;
    end
    @(posedge clk);
    #1;
    fb_rdy      = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    clear_req   = clear_pulse;
    clear_color = clear_col_next;
    clear_pulse = 0;
    if (stim_q.size() > 0) begin
      in_vld = 1'b1;
      {in_pixel, in_color} = stim_q[0];
    end else in_vld = 1'b0;
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || clear_busy || clear_req) && used < budget) begin
      step();
      used++;
    end
    check("drain_in_budget", (used < budget), 1);
  endtask

  initial begin
    int used, acc0, fw0, inb0;
    logic [16:0] hold_a;
    logic [COLOR_W-1:0] hold_d;
    rst = 1; in_vld = 0; in_pixel = '0; in_color = '0; clear_req = 0;
    clear_color = '0; fb_rdy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_wdata", fb_wdata, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_drop_count", drop_count, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(negedge clk);
    check("rdy_after_reset", in_rdy, 1);
    @(posedge clk); #1;

    // single fragment, one-cycle latency
    rdy_mode = 1; fb_rdy = 1;
    stim_q.push_back(make_frag(5 * 16, 2 * 16, 24'h11AA55));
    step(); step();
    @(negedge clk);
    check("lat_we", fb_we, 1);
    check("lat_addr", fb_addr, 645);
    check("lat_data", fb_wdata, 24'h11AA55);
    @(posedge clk); #1;
    drain(50, used);
    check("drop_zero", drop_count, 0);

    // off-screen fragments, then the far corner
    stim_q.push_back(make_frag(-16, 0, 24'h000001));
    stim_q.push_back(make_frag(320 * 16, 0, 24'h000002));
    stim_q.push_back(make_frag(0, 240 * 16, 24'h000003));
    drain(50, used);
    check("drop_three", drop_count, 3);
    fw0 = n_frag_wr;
    stim_q.push_back(make_frag(319 * 16 + 12, 239 * 16 + 8, 24'hC0FFEE));
    drain(50, used);
    check("corner_written", n_frag_wr - fw0, 1);

    // back-pressure: in_rdy drops after 4 accepts, output held stable
    rdy_mode = 0; fb_rdy = 0; n_acc = 0;
    for (int i = 0; i < 8; i++)
      stim_q.push_back(make_frag(int'($urandom_range(0, FBW * 16 - 1)),
                                 int'($urandom_range(0, FBH * 16 - 1)),
                                 COLOR_W'($urandom)));
    repeat (20) step();
    check("bp_accepts", n_acc, 4);
    check("bp_we", fb_we, 1);
    hold_a = fb_addr; hold_d = fb_wdata;
    repeat (5) step();
    check("bp_hold_addr", fb_addr, hold_a);
    check("bp_hold_data", fb_wdata, hold_d);
    rdy_mode = 1; fb_rdy = 1;
    drain(100, used);
    check("bp_all_accepted", n_acc, 8);

    // full-rate stream
    for (int i = 0; i < 10; i++)
      stim_q.push_back(make_frag(int'($urandom_range(0, FBW * 16 - 1)),
                                 int'($urandom_range(0, FBH * 16 - 1)),
                                 COLOR_W'($urandom)));
    drain(100, used);
    check("throughput", (used <= 14), 1);

    // clear behind two queued fragments, with a redundant request mid-clear
    rdy_mode = 0; fb_rdy = 0; fw0 = n_frag_wr;
    stim_q.push_back(make_frag(10 * 16, 10 * 16, 24'h0A0A0A));
    stim_q.push_back(make_frag(20 * 16, 30 * 16, 24'h0B0B0B));
    repeat (4) step();
    clear_pulse = 1; clear_col_next = 24'h2C2C2C;
    step();
    rdy_mode = 1;
    repeat (500) step();
    clear_pulse = 1; clear_col_next = 24'h3D3D3D;
    step();
    drain(80000, used);
    check("clear_frag_first", n_frag_wr - fw0, 2);
    check("clear_writes", n_clear_wr, PIX);
    repeat (3) step();
    check("clear_busy_low", clear_busy, 0);

    // reset in the middle of a clear
    clear_pulse = 1; clear_col_next = 24'h4E4E4E;
    used = 0;
    while (!(fb_we && fb_addr == 17'd1000) && used < 3000) begin
      step();
      used++;
    end
    check("reached_addr_1000", (used < 3000), 1);
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_fb_we", fb_we, 0);
    check("abort_clear_busy", clear_busy, 0);
    @(posedge clk); #1;
    rst = 0;
    fw0 = n_frag_wr;
    stim_q.push_back(make_frag(7 * 16 + 3, 9 * 16 + 15, 24'h5F5F5F));
    drain(50, used);
    check("post_reset_write", n_frag_wr - fw0, 1);

    // random fragments with random memory back-pressure
    rdy_mode = 2; fw0 = n_frag_wr; inb0 = m_inb; acc0 = n_acc;
    for (int i = 0; i < 200; i++)
      stim_q.push_back(make_frag(int'($urandom_range(0, 400 * 16 - 1)) - 40 * 16,
                                 int'($urandom_range(0, 280 * 16 - 1)) - 20 * 16,
                                 COLOR_W'($urandom)));
    drain(5000, used);
    check("rand_accepted", n_acc - acc0, 200);
    check("rand_inbounds_written", n_frag_wr - fw0, m_inb - inb0);
    check("rand_drop_count", drop_count, m_drop);
    rdy_mode = 1;
    repeat (5) step();
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
